// File: rtl/game_pkg.sv
// Shared encodings for the brick-game flow controller.
// Latency: none (constants and types only).
// Backpressure: none.
package game_pkg;

    localparam int STATE_W        = 3;
    localparam int TICK_PERIOD_MS = 50;

    typedef enum logic [STATE_W-1:0] {
        ST_MENU  = 3'd0,
        ST_WIN   = 3'd1,
        ST_LOSE  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_LOAD  = 3'd4,
        ST_PAUSE = 3'd5
    } game_state_t;

endpackage

// File: rtl/skill_pool.sv
// Skill-point pool: tick-driven regeneration counter, saturating point store, lowest-index grant arbiter.
// Latency: grant pulse and point update appear on the clk edge that samples tick.
// Backpressure: none; requests not granted in their tick are dropped.
module skill_pool
#(
    parameter int  SKILL_MAX    = 3,
    parameter int  SKILL_PERIOD = 200,
    parameter int  NUM_SKILLS   = 3,
    localparam int KW           = $clog2(SKILL_MAX + 1),
    localparam int CW           = $clog2(SKILL_PERIOD)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  pool_clr,
    input  logic                  ctr_clr,
    input  logic                  run,
    input  logic [NUM_SKILLS-1:0] skill_req,
    input  logic [NUM_SKILLS-1:0] skill_active,
    output logic [KW-1:0]         skill_point,
    output logic [NUM_SKILLS-1:0] skill_grant
);

    logic [CW-1:0]         ctr_q;
    logic [NUM_SKILLS-1:0] cand;
    logic [NUM_SKILLS-1:0] pick;
    logic                  wrap;
    logic                  give;
    logic [KW-1:0]         point_d;

    assign cand = skill_req & ~skill_active;
    // Isolate the lowest set bit: that is the winning channel.
    assign pick = cand & (~cand + 1'b1);
    assign wrap = run && (ctr_q == CW'(SKILL_PERIOD - 1));
    assign give = run && (|cand) && (skill_point != '0);

    always_comb begin
        point_d = skill_point;
        if (give) begin
            point_d = point_d - 1'b1;
        end
        if (wrap && (point_d != KW'(SKILL_MAX))) begin
            point_d = point_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q       <= '0;
            skill_point <= '0;
            skill_grant <= '0;
        end else begin
            skill_grant <= (tick && give) ? pick : '0;
            if (tick) begin
                skill_point <= pool_clr ? '0 : point_d;
                if (ctr_clr) begin
                    ctr_q <= '0;
                end else if (run) begin
                    ctr_q <= wrap ? '0 : ctr_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Brick-game flow sequencer: menu/load/play/win/lose FSM, stage index, lives, skill pool (optional PAUSE via GAME_PAUSE_EN).
// Latency: every state change and the stage_load/skill_grant pulses land on the clk edge that samples tick.
// Backpressure: none; inputs are sampled only with tick, events outside a tick are not seen.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int  NUM_STAGES   = 3,
    parameter int  LIVES_INIT   = 5,
    parameter int  SKILL_MAX    = 3,
    parameter int  SKILL_PERIOD = 200,
    parameter int  NUM_SKILLS   = 3,
    localparam int SW           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int KW           = $clog2(SKILL_MAX + 1)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start_press,
    input  logic                  ball_lost,
    input  logic                  stage_clear,
    input  logic [NUM_SKILLS-1:0] skill_req,
    input  logic [NUM_SKILLS-1:0] skill_active,
    output logic [STATE_W-1:0]    state,
    output logic [SW-1:0]         stage_idx,
    output logic                  stage_load,
    output logic [7:0]            life_point,
    output logic [KW-1:0]         skill_point,
    output logic [NUM_SKILLS-1:0] skill_grant
);

    game_state_t st_q;
    game_state_t st_d;
    logic [SW-1:0] stage_d;
    logic [7:0]    life_d;
    logic          lost_q;
    logic          lost_evt;
    logic          pause_req;
    logic          pool_clr;
    logic          ctr_clr;
    logic          pool_run;

    assign state    = st_q;
    // A held ball_lost level costs one life: only its rising edge (tick-sampled) counts.
    assign lost_evt = ball_lost & ~lost_q;

`ifdef GAME_PAUSE_EN
    assign pause_req = start_press;
`else
    assign pause_req = 1'b0;
`endif

    always_comb begin
        st_d     = st_q;
        stage_d  = stage_idx;
        life_d   = life_point;
        pool_clr = 1'b0;
        ctr_clr  = 1'b0;
        pool_run = 1'b0;
        case (st_q)
            ST_MENU: begin
                if (start_press) begin
                    st_d     = ST_LOAD;
                    stage_d  = '0;
                    life_d   = 8'(LIVES_INIT);
                    pool_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                st_d    = ST_PLAY;
                ctr_clr = 1'b1;
            end
            ST_PLAY: begin
                // Skill/regen only run on ticks where no higher-priority event fires.
                if (stage_clear) begin
                    if (stage_idx == SW'(NUM_STAGES - 1)) begin
                        st_d = ST_WIN;
                    end else begin
                        stage_d = stage_idx + 1'b1;
                        st_d    = ST_LOAD;
                    end
                end else if (lost_evt) begin
                    life_d = life_point - 8'd1;
                    if (life_point == 8'd1) begin
                        st_d = ST_LOSE;
                    end
                end else if (pause_req) begin
                    st_d = ST_PAUSE;
                end else begin
                    pool_run = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (start_press) begin
                    st_d = ST_PLAY;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start_press) begin
                    st_d = ST_MENU;
                end
            end
            default: begin
                st_d = ST_MENU;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= ST_MENU;
            stage_idx  <= '0;
            life_point <= 8'(LIVES_INIT);
            stage_load <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            stage_load <= tick && (st_q == ST_LOAD);
            if (tick) begin
                st_q       <= st_d;
                stage_idx  <= stage_d;
                life_point <= life_d;
                lost_q     <= ball_lost;
            end
        end
    end

    skill_pool #(
        .SKILL_MAX    (SKILL_MAX),
        .SKILL_PERIOD (SKILL_PERIOD),
        .NUM_SKILLS   (NUM_SKILLS)
    ) u_skill_pool (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .pool_clr     (pool_clr),
        .ctr_clr      (ctr_clr),
        .run          (pool_run),
        .skill_req    (skill_req),
        .skill_active (skill_active),
        .skill_point  (skill_point),
        .skill_grant  (skill_grant)
    );

endmodule
